// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the framer state enum, word-length codes, word field indices and parity.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  localparam logic [1:0] NB_5 = 2'b00;
  localparam logic [1:0] NB_6 = 2'b01;
  localparam logic [1:0] NB_7 = 2'b10;
  localparam logic [1:0] NB_8 = 2'b11;

  localparam int D_BI = 10;
  localparam int D_FE = 9;
  localparam int D_PE = 8;

  // XOR of the low 5..8 data bits selected by num_bits.
  function automatic logic parity_calc(
    input logic [7:0] data,
    input logic [1:0] num_bits
  );
    logic [7:0] mask;
    case (num_bits)
      NB_5:    mask = 8'h1F;
      NB_6:    mask = 8'h3F;
      NB_7:    mask = 8'h7F;
      NB_8:    mask = 8'hFF;
      default: mask = 8'hFF;
    endcase
    return ^(data & mask);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; idles and resets high.
// Ports: clk, rst (sync, active-high), rx_i (async in), rxs_o (synchronized out).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rxs_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], rx_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rxs_o = sync_q[1];

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: oversampled start/data/parity/stop recovery into FIFO words.
// Ports: clk, rst, brc, rx, mode inputs, fifo_full, clr_overrun -> wr, d, overrun, busy.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int OSR = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        brc,
  input  logic        rx,
  input  logic [1:0]  num_bits,
  input  logic        parity_en,
  input  logic        parity_even,
  input  logic        parity_sticky,
  input  logic        fifo_full,
  input  logic        clr_overrun,
  output logic        wr,
  output logic [10:0] d,
  output logic        overrun,
  output logic        busy
);

  localparam int TW = $clog2(OSR);
  localparam logic [TW-1:0] T_HALF = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OSR - 1);

  logic rxs;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .rx_i  (rx),
    .rxs_o (rxs)
  );

  rx_state_t   state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        par_q, par_d;
  logic        any1_q, any1_d;
  logic [1:0]  nb_q, nb_d;
  logic        pen_q, pen_d;
  logic        pev_q, pev_d;
  logic        pst_q, pst_d;
  logic        wr_q, wr_d;
  logic [10:0] d_q, d_d;
  logic        ovr_q, ovr_d;

  logic samp;
  logic last_bit;
  logic exp_par;
  logic pe;
  logic fe;
  logic bi;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    data_d   = data_q;
    par_d    = par_q;
    any1_d   = any1_q;
    nb_d     = nb_q;
    pen_d    = pen_q;
    pev_d    = pev_q;
    pst_d    = pst_q;
    wr_d     = 1'b0;
    d_d      = d_q;
    ovr_d    = ovr_q & ~clr_overrun;
    exp_par  = 1'b0;
    pe       = 1'b0;
    fe       = 1'b0;
    bi       = 1'b0;
    samp     = brc && (tick_q == T_FULL);
    last_bit = (bit_q == (3'(nb_q) + 3'd4));

    // Mid-bit tick counter for the sampling states.
    if (brc && state_q inside {DATA, PARITY, STOP}) begin
      tick_d = samp ? '0 : tick_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (brc) begin
          if (tick_q == T_HALF) begin
            tick_d = '0;
            if (rxs) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              bit_d   = '0;
              data_d  = '0;
              par_d   = 1'b0;
              any1_d  = 1'b0;
              nb_d    = num_bits;
              pen_d   = parity_en;
              pev_d   = parity_even;
              pst_d   = parity_sticky;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (samp) begin
          data_d[bit_q] = rxs;
          any1_d = any1_q | rxs;
          bit_d  = bit_q + 3'd1;
          if (last_bit) begin
            state_d = pen_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (samp) begin
          par_d   = rxs;
          any1_d  = any1_q | rxs;
          state_d = STOP;
        end
      end
      STOP: begin
        if (samp) begin
          if (pst_q) begin
            exp_par = ~pev_q;
          end else begin
            exp_par = parity_calc(data_q, nb_q) ^ ~pev_q;
          end
          pe = pen_q & (par_q != exp_par);
          fe = ~rxs;
          bi = ~any1_q & ~rxs;
          d_d[7:0]  = data_q;
          d_d[D_PE] = pe;
          d_d[D_FE] = fe;
          d_d[D_BI] = bi;
          // A full FIFO drops the word; set beats a same-cycle clear.
          if (fifo_full) begin
            ovr_d = 1'b1;
          end else begin
            wr_d = 1'b1;
          end
          state_d = bi ? BRK_WAIT : IDLE;
        end
      end
      BRK_WAIT: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      any1_q  <= 1'b0;
      nb_q    <= NB_8;
      pen_q   <= 1'b0;
      pev_q   <= 1'b0;
      pst_q   <= 1'b0;
      wr_q    <= 1'b0;
      d_q     <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      any1_q  <= any1_d;
      nb_q    <= nb_d;
      pen_q   <= pen_d;
      pev_q   <= pev_d;
      pst_q   <= pst_d;
      wr_q    <= wr_d;
      d_q     <= d_d;
      ovr_q   <= ovr_d;
    end
  end

  assign wr      = wr_q;
  assign d       = d_q;
  assign overrun = ovr_q;
  assign busy    = (state_q != IDLE);

endmodule
